// File: rtl/seq_source_if.sv
// Write-side link into the CDC buffer: the producer offers a word, the buffer pushes back with buffer_full.
// data_1_en is combinational from the producer's pending flag and buffer_full, so it is valid in the same cycle.
interface seq_source_if;
    logic        data_1_en;
    logic [15:0] data_1;
    logic        buffer_full;

    modport master (
        output data_1_en,
        output data_1,
        input  buffer_full
    );

    modport slave (
        input  data_1_en,
        input  data_1,
        output buffer_full
    );
endinterface

// File: rtl/seq_source.sv
// Fibonacci / countdown word source; the first word is pending from the start edge and words stream every PACE cycles.
// buffer_full stalls the pending word in place; nothing is skipped or repeated while the buffer pushes back.
module seq_source #(
    parameter int PACE = 1
) (
    input  logic         clk_1,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [15:0]  timer_init,
    output logic         busy,
    output logic         done,
    seq_source_if.master bus
);

    localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic [15:0]   data_q,  data_d;
    logic [15:0]   a_q,     a_d;
    logic [16:0]   b_q,     b_d;
    logic          mode_q,  mode_d;
    logic [PW-1:0] pace_q,  pace_d;

    logic accept;
    logic last_word;

    assign accept    = valid_q & ~bus.buffer_full;
    // Fibonacci ends when the successor no longer fits in 16 bits; the timer ends on 0.
    assign last_word = mode_q ? (data_q == 16'd0) : b_q[16];

    assign bus.data_1_en = accept;
    assign bus.data_1    = data_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        pace_d  = pace_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    valid_d = 1'b1;
                    mode_d  = mode;
                    data_d  = mode ? timer_init : 16'd0;
                    a_d     = 16'd0;
                    b_d     = 17'd1;
                    pace_d  = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (last_word) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                    end else begin
                        if (mode_q) begin
                            data_d = data_q - 16'd1;
                        end else begin
                            data_d = b_q[15:0];
                            a_d    = b_q[15:0];
                            b_d    = {1'b0, a_q} + b_q;
                        end
                        if (PACE > 1) begin
                            valid_d = 1'b0;
                            pace_d  = PW'(PACE - 1);
                        end
                    end
                end else if (!valid_q && (pace_q != '0)) begin
                    // Re-arm one cycle early so acceptances land exactly PACE edges apart.
                    pace_d = pace_q - PW'(1);
                    if (pace_q == PW'(1)) begin
                        valid_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            data_q  <= 16'd0;
            a_q     <= 16'd0;
            b_q     <= 17'd0;
            mode_q  <= 1'b0;
            pace_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            pace_q  <= pace_d;
        end
    end

endmodule
